// File: rtl/ln_mean_ctrl.sv
// rtl/ln_mean_ctrl.sv - LayerNorm mean sequencer: chunk feed, tag pipeline, accumulator, 2-deep output FIFO
module ln_mean_ctrl #(
  parameter int NCHUNK      = 4,
  parameter int LOG2_NCHUNK = 2,
  parameter int TREE_LAT    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  input  logic         in_last,
  output logic [255:0] tree_x_flat,
  input  logic [15:0]  tree_mean,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_mean,
  output logic         err_len
);

  // Counter width stays at least one bit so NCHUNK=1 still elaborates.
  localparam int CW = (LOG2_NCHUNK > 0) ? LOG2_NCHUNK : 1;
  localparam int AW = 16 + LOG2_NCHUNK;
  // Wide enough for fifo_count (max 2) plus every tag marked last.
  localparam int IW = $clog2(TREE_LAT + 3);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  logic [CW-1:0]       in_cnt;
  logic [CW-1:0]       res_cnt;
  logic [TREE_LAT-1:0] tag_v;
  logic [TREE_LAT-1:0] tag_l;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic [15:0]         fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          fifo_count;
  logic [IW-1:0]       inflight_last;
  logic                accept;
  logic                in_slot_last;
  logic                res_v;
  logic                res_last;
  logic                res_first;
  logic                push;
  logic                push_ok;
  logic                pop;
  logic [15:0]         push_data;

  // Count tags still travelling through the tree that will each produce a FIFO push.
  always_comb begin
    inflight_last = '0;
    for (int i = 0; i < TREE_LAT; i++) begin
      inflight_last = inflight_last + IW'(tag_l[i]);
    end
  end

  // Input handshake: only a last-chunk slot is ever held back, and only on registered state.
  always_comb begin
    in_slot_last = (in_cnt == LAST_IDX);
    in_ready     = !rst && (!in_slot_last ||
                            ((IW'(fifo_count) + inflight_last) < IW'(2)));
    accept       = in_valid && in_ready;
    tree_x_flat  = accept ? in_data : '0;
  end

  // Result side: the last tag stage lines up with the chunk mean on tree_mean.
  always_comb begin
    res_v     = tag_v[TREE_LAT-1];
    res_last  = tag_l[TREE_LAT-1];
    res_first = (res_cnt == '0);
    sum       = (res_first ? '0 : acc) + AW'(tree_mean);
    push      = res_v && res_last;
    push_data = 16'(sum >> LOG2_NCHUNK);
    out_valid = (fifo_count != 2'd0);
    out_mean  = fifo_mem[rd_ptr];
    pop       = out_valid && out_ready;
    push_ok   = push && ((fifo_count != 2'd2) || pop);
  end

  // Input chunk counter; framing follows this count, never in_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
    end else if (accept) begin
      in_cnt <= in_slot_last ? '0 : in_cnt + 1'b1;
    end
  end

  // Tag pipeline shifts every cycle because the tree itself never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= accept;
      tag_l[0] <= accept && in_slot_last;
      for (int i = 1; i < TREE_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  // Accumulate returned chunk means; a first chunk restarts the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt <= '0;
      acc     <= '0;
    end else if (res_v) begin
      acc     <= sum;
      res_cnt <= res_last ? '0 : res_cnt + 1'b1;
    end
  end

  // FIFO storage; contents are qualified by fifo_count so they need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Flag a producer end-of-vector marker that disagrees with our own framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_len <= 1'b0;
    end else begin
      err_len <= accept && (in_last != in_slot_last);
    end
  end

endmodule

// File: tb/tb_ln_mean_ctrl.sv
// tb/tb_ln_mean_ctrl.sv - scoreboard bench for ln_mean_ctrl with a behavioural adder tree
module tb_ln_mean_ctrl;
  localparam int NCHUNK = 4;
  localparam int LOG2   = 2;
  localparam int TLAT   = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         in_last;
  logic [255:0] tree_x_flat;
  logic [15:0]  tree_mean;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_mean;
  logic         err_len;

  logic         ready_cmd = 1'b1;
  logic         rnd_en = 1'b0;
  logic         rnd_bit = 1'b1;
  logic [15:0]  tree_pipe [TLAT];
  logic [15:0]  exp_q [$];
  int           total = 0;
  int           bad = 0;
  int           pops = 0;
  int           errs = 0;
  int           cyc = 0;
  int           rise_cyc = -1;
  logic         prev_valid = 1'b0;

  always #5 clk = ~clk;

  assign out_ready = rnd_en ? rnd_bit : ready_cmd;
  assign tree_mean = tree_pipe[TLAT-1];

  ln_mean_ctrl #(.NCHUNK(NCHUNK), .LOG2_NCHUNK(LOG2), .TREE_LAT(TLAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .tree_x_flat(tree_x_flat),
    .tree_mean(tree_mean), .out_valid(out_valid), .out_ready(out_ready),
    .out_mean(out_mean), .err_len(err_len)
  );

  function automatic logic [15:0] lane_mean(input logic [255:0] d);
    logic [19:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + 20'(d[16*i +: 16]);
    return s[19:4];
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v, input bit spread);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = v + (spread ? 16'(i) : 16'd0);
    return r;
  endfunction

  // behavioural tree: TLAT register stages
  always @(posedge clk) begin
    tree_pipe[0] <= lane_mean(tree_x_flat);
    for (int i = 1; i < TLAT; i++) tree_pipe[i] <= tree_pipe[i-1];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rnd_en) rnd_bit <= 1'($urandom_range(0, 1));
  end

  // output monitor: pop scoreboard on every handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      if (err_len) errs++;
      if (out_valid && out_ready) begin
        logic [15:0] e;
        total++;
        pops++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got %h with empty scoreboard", out_mean);
        end else begin
          e = exp_q.pop_front();
          if (out_mean !== e) begin
            bad++;
            $display("FAIL out_mean: got %h expected %h", out_mean, e);
          end
        end
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_chunk(input logic [255:0] d, input logic l);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%b expected 1 within 60 cycles", in_ready);
    end
  endtask

  task automatic send_vector(input logic [255:0] ch [4], input bit [3:0] lastm);
    logic [19:0] a;
    a = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      send_chunk(ch[k], lastm[k]);
      a = a + 20'(lane_mean(ch[k]));
    end
    exp_q.push_back(16'(a >> LOG2));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    repeat (TLAT + 4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    idle();
    ready_cmd = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
    total++;
    if (err_len !== 1'b0) begin bad++; $display("FAIL post_reset_err_len: got %b expected 0", err_len); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    logic [255:0] ch [4];
    int start;
    int e0;
    for (int k = 0; k < 4; k++) ch[k] = fill(16'h0100, 1'b0);
    e0 = errs;
    rise_cyc = -1;
    start = cyc;
    send_vector(ch, 4'b1000);
    idle();
    drain(40);
    total++;
    if (rise_cyc != start + NCHUNK + TLAT) begin
      bad++;
      $display("FAIL latency: out_valid rose at cycle %0d expected %0d", rise_cyc - start, NCHUNK + TLAT);
    end
    total++;
    if (errs != e0) begin bad++; $display("FAIL latency_err_len: got %0d pulses expected 0", errs - e0); end
  endtask

  task automatic test_ramp_and_saturate();
    logic [255:0] ch [4];
    for (int k = 0; k < 4; k++) ch[k] = fill(16'((k + 1) << 8), 1'b0);
    send_vector(ch, 4'b1000);
    for (int k = 0; k < 4; k++) ch[k] = fill(16'hFFFF, 1'b0);
    send_vector(ch, 4'b1000);
    idle();
    drain(40);
  endtask

  task automatic test_backpressure();
    logic [255:0] ch [4];
    logic [19:0] a;
    int p0;
    int hi;
    p0 = pops;
    ready_cmd = 1'b0;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 4; k++) ch[k] = fill(16'(16'h1000 * (v + 1) + 16'h0040 * k), 1'b1);
      send_vector(ch, 4'b1000);
    end
    a = '0;
    for (int k = 0; k < 3; k++) begin
      ch[k] = fill(16'(16'h3000 + 16'h0100 * k), 1'b1);
      send_chunk(ch[k], 1'b0);
      a = a + 20'(lane_mean(ch[k]));
    end
    ch[3] = fill(16'h3500, 1'b1);
    in_valid = 1'b1;
    in_data  = ch[3];
    in_last  = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) hi++;
      @(posedge clk);
      #1;
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL stall_in_ready: high for %0d cycles expected 0", hi); end
    total++;
    if (out_valid !== 1'b1 || out_mean !== exp_q[0]) begin
      bad++;
      $display("FAIL stall_head: valid=%b mean=%h expected valid=1 mean=%h", out_valid, out_mean, exp_q[0]);
    end
    ready_cmd = 1'b1;
    send_chunk(ch[3], 1'b1);
    a = a + 20'(lane_mean(ch[3]));
    exp_q.push_back(16'(a >> LOG2));
    idle();
    drain(40);
    total++;
    if (pops - p0 != 3) begin bad++; $display("FAIL bp_count: got %0d outputs expected 3", pops - p0); end
  endtask

  task automatic test_err_len();
    logic [255:0] ch [4];
    int e0;
    e0 = errs;
    for (int k = 0; k < 4; k++) ch[k] = fill(16'(16'h0200 + 16'h0010 * k), 1'b1);
    send_vector(ch, 4'b0100);
    idle();
    drain(40);
    total++;
    if (errs - e0 != 2) begin bad++; $display("FAIL err_len_count: got %0d pulses expected 2", errs - e0); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] ch [4];
    int p0;
    send_chunk(fill(16'h0700, 1'b0), 1'b0);
    send_chunk(fill(16'h0900, 1'b0), 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = pops;
    for (int k = 0; k < 4; k++) ch[k] = fill(16'h0300, 1'b0);
    send_vector(ch, 4'b1000);
    idle();
    drain(40);
    total++;
    if (pops - p0 != 1) begin bad++; $display("FAIL reset_mid_count: got %0d outputs expected 1", pops - p0); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ch [4];
    int p0;
    p0 = pops;
    rnd_en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < 16; i++) ch[k][16*i +: 16] = 16'($urandom);
      send_vector(ch, 4'b1000);
    end
    idle();
    drain(200);
    rnd_en = 1'b0;
    total++;
    if (pops - p0 != 5) begin bad++; $display("FAIL b2b_count: got %0d outputs expected 5", pops - p0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_latency();
    test_ramp_and_saturate();
    test_backpressure();
    test_err_len();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
